interp_fir_x4: RTL and testbench
================================

INTERP_FIR_X4 -- requirements
Module: interp_fir_x4

Interface
REQ-001 Parameter WIDTH, default 16: sample width, two's complement, for data_i and data_o.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 valid_i  input  1  data_i carries a valid baseband sample.
REQ-005 ready_o  output  1  block can accept a sample this cycle.
REQ-006 data_i  input  WIDTH  input sample, format 1.15.
REQ-007 valid_o  output  1  data_o carries a valid interpolated sample.
REQ-008 ready_i  input  1  downstream accepts data_o this cycle.
REQ-009 data_o  output  WIDTH  output sample, format 1.15, registered.

Function
REQ-010 The block SHALL be a 16-tap, interpolate-by-4 polyphase FIR with one time-multiplexed multiplier; 4 phases, 4 taps per phase.
REQ-011 Fixed coefficients h[0..15] (Q1.15) SHALL be: 0, 83, 188, 481, 1030, 1818, 2734, 3600, 4222, 4448, 4222, 3600, 2734, 1818, 1030, 481.
REQ-012 A 4-entry delay line x[0..3] SHALL hold the newest input in x[0] and the oldest in x[3].
REQ-013 Input handshake: a sample SHALL be accepted only in a cycle with valid_i=1 and ready_o=1; on acceptance x[0]<=data_i and x[k]<=x[k-1] for k=1..3.
REQ-014 ready_o SHALL be 1 only in state IDLE; valid_i while ready_o=0 SHALL be ignored and SHALL NOT alter the delay line.
REQ-015 FSM states: IDLE, MAC, OUT; reset state IDLE.
REQ-016 IDLE -> MAC on input acceptance, with phase p=0, tap index k=0, accumulator cleared.
REQ-017 MAC SHALL last exactly 4 cycles; cycle k adds h[4k+p]*x[k] to the accumulator; after k=3, go to OUT.
REQ-018 Products SHALL be signed 2*WIDTH bits; accumulator SHALL be signed 2*WIDTH+2 bits, with no overflow possible.
REQ-019 On MAC -> OUT, data_o SHALL be loaded with acc >>> 13 (arithmetic, floor; x4 interpolation gain compensation), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 In OUT, valid_o SHALL be 1, and data_o SHALL be held stable until a cycle with ready_i=1.
REQ-021 On the output handshake with p<3: p<=p+1, k<=0, accumulator cleared, go to MAC; with p=3: go to IDLE.
REQ-022 valid_o SHALL be 0 in IDLE and MAC.
REQ-023 Latency: input accepted at cycle T -> first valid_o=1 at T+5; with ready_i held 1, the outputs SHALL appear at T+5, T+10, T+15, T+20, and ready_o SHALL be 1 again at T+21.
REQ-024 Output order per input SHALL be phase 0, 1, 2, 3.

Reset
REQ-025 rst=1 SHALL force state IDLE, p=0, k=0, accumulator=0, x[0..3]=0, data_o=0, valid_o=0 on the next edge, and ready_o=1 after that edge.
REQ-026 rst asserted in MAC or OUT SHALL abort the current sample; no further outputs for it SHALL be produced.
REQ-027 rst SHALL take priority over simultaneous valid_i or ready_i.

Verification
REQ-028 Impulse test: data_i=16384 followed by three inputs of 0, ready_i=1 -> data_o sequence 0, 166, 376, 962, 2060, 3636, 5468, 7200, 8444, 8896, 8444, 7200, 5468, 3636, 2060, 962.
REQ-029 DC test: repeat data_i=-32768 until the delay line is full -> per-input outputs -31944, -32668, -32696, -32648.
REQ-030 Backpressure test: hold ready_i=0 for 10 cycles in OUT -> valid_o=1 and data_o unchanged on every cycle; the next phase starts on the cycle after ready_i=1.
REQ-031 Busy test: toggle valid_i with random data_i during MAC/OUT -> ready_o=0 and the delay line unchanged; the impulse-test outputs are reproduced exactly.
REQ-032 Reset test: assert rst during MAC of phase 2 -> next cycle valid_o=0, data_o=0, ready_o=1; a fresh impulse afterwards reproduces the REQ-028 sequence.
REQ-033 Throughput test: valid_i=1 and ready_i=1 continuously -> one input accepted every 21 cycles and 4 outputs per input.

Source files
------------

// File: rtl/interp_fir_x4.sv
// Interpolate-by-4 polyphase FIR: 16 taps, 4 phases of 4 taps, one shared multiplier.
// Each accepted input yields four outputs (phase 0..3), each computed over 4 MAC cycles.
module interp_fir_x4 #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic signed [WIDTH-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic signed [WIDTH-1:0] data_o
);

    localparam int AW = 2 * WIDTH + 2;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              phase;
    logic [1:0]              tap;
    logic signed [AW-1:0]    acc;
    logic signed [WIDTH-1:0] x [4];

    logic signed [WIDTH-1:0]   coef;
    logic signed [2*WIDTH-1:0] coef_ext;
    logic signed [2*WIDTH-1:0] samp_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      acc_sum;
    logic signed [AW-1:0]      acc_shift;
    logic signed [WIDTH-1:0]   sat_val;

    // Coefficient index is 4*tap + phase, i.e. the concatenation {tap, phase}.
    always_comb begin
        coef = '0;
        case ({tap, phase})
            4'd1:  coef = WIDTH'(83);
            4'd2:  coef = WIDTH'(188);
            4'd3:  coef = WIDTH'(481);
            4'd4:  coef = WIDTH'(1030);
            4'd5:  coef = WIDTH'(1818);
            4'd6:  coef = WIDTH'(2734);
            4'd7:  coef = WIDTH'(3600);
            4'd8:  coef = WIDTH'(4222);
            4'd9:  coef = WIDTH'(4448);
            4'd10: coef = WIDTH'(4222);
            4'd11: coef = WIDTH'(3600);
            4'd12: coef = WIDTH'(2734);
            4'd13: coef = WIDTH'(1818);
            4'd14: coef = WIDTH'(1030);
            4'd15: coef = WIDTH'(481);
            default: coef = '0;
        endcase
    end

    always_comb begin
        coef_ext  = (2 * WIDTH)'(coef);
        samp_ext  = (2 * WIDTH)'(x[tap]);
        prod      = coef_ext * samp_ext;
        acc_sum   = acc + AW'(prod);
        // Shift by 13 rather than 15 restores the x4 gain lost to zero-stuffing.
        acc_shift = acc_sum >>> 13;
        if (acc_shift > SAT_MAX) begin
            sat_val = SAT_MAX[WIDTH-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_val = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_val = acc_shift[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            tap     <= '0;
            acc     <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                x[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        x[0]    <= data_i;
                        x[1]    <= x[0];
                        x[2]    <= x[1];
                        x[3]    <= x[2];
                        phase   <= '0;
                        tap     <= '0;
                        acc     <= '0;
                        ready_o <= 1'b0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (tap == 2'd3) begin
                        data_o  <= sat_val;
                        valid_o <= 1'b1;
                        state   <= OUT;
                    end else begin
                        tap <= tap + 2'd1;
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        if (phase == 2'd3) begin
                            ready_o <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            phase <= phase + 2'd1;
                            tap   <= '0;
                            acc   <= '0;
                            state <= MAC;
                        end
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interp_fir_x4.sv
// Bench for interp_fir_x4: random and directed stimulus against a polyphase
// convolution model of the interpolator.
module tb_interp_fir_x4;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] data_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          mx[4];
    bit          rand_ready = 0;

    int H[16]   = '{0, 83, 188, 481, 1030, 1818, 2734, 3600, 4222, 4448, 4222, 3600, 2734, 1818, 1030, 481};
    int IMP[16] = '{0, 166, 376, 962, 2060, 3636, 5468, 7200, 8444, 8896, 8444, 7200, 5468, 3636, 2060, 962};
    int DCV[4]  = '{-31944, -32668, -32696, -32648};

    interp_fir_x4 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output handshakes are recorded mid-cycle, when ready_i and valid_o are stable.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) got_q.push_back(data_o);
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    end

    // Model: output phase p = floor(sum_k h[4k+p]*x[k] / 2^13), saturated to 16 bits.
    function automatic void model_push(input logic signed [15:0] d);
        longint s;
        mx[3] = mx[2];
        mx[2] = mx[1];
        mx[1] = mx[0];
        mx[0] = int'(d);
        for (int p = 0; p < 4; p++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += longint'(H[4*k+p]) * longint'(mx[k]);
            s = s >>> 13;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp_q.push_back(16'(s));
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_i = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mx[i] = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic send(input logic signed [15:0] d, output bit ok);
        int n = 0;
        while (ready_o !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        ok = (ready_o === 1'b1);
        if (ok) begin
            valid_i = 1'b1;
            data_i  = d;
            model_push(d);
            step();
            valid_i = 1'b0;
        end
    endtask

    task automatic wait_got(input int n, output bit ok);
        int c = 0;
        while (got_q.size() < n && c < 2000) begin
            step();
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i = '0;
        step();
        step();
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++;
        if (data_o !== 16'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", $signed(data_o)); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_impulse();
        bit ok;
        int n;
        do_reset();
        ready_i = 1'b1;
        send(16'sd16384, ok);
        n = 1;
        while (valid_o !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (n != 5) begin errors++; $display("FAIL impulse_latency got=%0d exp=5", n); end
        while (ready_o !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (n != 21) begin errors++; $display("FAIL impulse_ready_back got=%0d exp=21", n); end
        for (int i = 0; i < 3; i++) send(16'sd0, ok);
        wait_got(16, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL impulse_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 16'(IMP[i])) begin
                errors++;
                $display("FAIL impulse[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), IMP[i]);
            end
        end
    endtask

    task automatic test_dc();
        bit ok;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) send(-16'sd32768, ok);
        wait_got(16, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dc_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL dc_model[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), $signed(exp_q[i]));
            end
        end
        for (int p = 0; p < 4 && 12 + p < got_q.size(); p++) begin
            checks++;
            if (got_q[12+p] !== 16'(DCV[p])) begin
                errors++;
                $display("FAIL dc_full[%0d] got=%0d exp=%0d", p, $signed(got_q[12+p]), DCV[p]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [15:0] d;
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: d = 16'h7fff;
                1: d = 16'h8000;
                default: d = 16'($urandom);
            endcase
            send(d, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL random_send[%0d] got=timeout exp=accept", i); end
        end
        wait_got(40, ok);
        rand_ready = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (!ok) begin errors++; $display("FAIL random_count got=%0d exp=40", got_q.size()); end
        for (int i = 0; i < 40 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), $signed(exp_q[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        logic [15:0] held;
        do_reset();
        ready_i = 1'b0;
        send(16'($urandom_range(1000, 30000)), ok);
        n = 0;
        while (valid_o !== 1'b1 && n < 50) begin step(); n++; end
        held = data_o;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (valid_o !== 1'b1 || data_o !== held) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=%b/%0d exp=1/%0d", i, valid_o, $signed(data_o), $signed(held));
            end
        end
        ready_i = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", valid_o); end
        n = 1;
        while (valid_o !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (n != 5) begin errors++; $display("FAIL bp_next_phase got=%0d exp=5", n); end
        wait_got(4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), $signed(exp_q[i]));
            end
        end
    endtask

    task automatic test_busy();
        bit ok;
        logic [15:0] d;
        do_reset();
        ready_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            d = (s == 0) ? 16'd16384 : 16'd0;
            checks++;
            if (ready_o !== 1'b1) begin errors++; $display("FAIL busy_ready_back[%0d] got=%b exp=1", s, ready_o); end
            valid_i = 1'b1;
            data_i  = d;
            step();
            for (int j = 1; j <= 20; j++) begin
                checks++;
                if (ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready[%0d/%0d] got=%b exp=0", s, j, ready_o); end
                valid_i = 1'($urandom_range(0, 1));
                data_i  = 16'($urandom);
                step();
            end
            valid_i = 1'b0;
        end
        wait_got(16, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL busy_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 16'(IMP[i])) begin
                errors++;
                $display("FAIL busy[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), IMP[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        ready_i = 1'b1;
        send(16'sd16384, ok);
        wait_got(2, ok);
        // Phase-1 handshake just completed: the block is now in MAC of phase 2.
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", valid_o); end
        checks++;
        if (data_o !== 16'd0) begin errors++; $display("FAIL rmid_data got=%0d exp=0", $signed(data_o)); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", ready_o); end
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL rmid_abort got=%0d exp=2", got_q.size()); end
        do_reset();
        send(16'sd16384, ok);
        for (int i = 0; i < 3; i++) send(16'sd0, ok);
        wait_got(16, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 16'(IMP[i])) begin
                errors++;
                $display("FAIL rmid_impulse[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), IMP[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n_acc = 0;
        int acc_cyc[4];
        do_reset();
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'($urandom);
        for (int cyc = 0; cyc < 300 && n_acc < 4; cyc++) begin
            if (ready_o === 1'b1) begin
                model_push(data_i);
                acc_cyc[n_acc] = cyc;
                n_acc++;
                step();
                data_i = 16'($urandom);
                if (n_acc == 4) valid_i = 1'b0;
            end else begin
                step();
            end
        end
        valid_i = 1'b0;
        checks++;
        if (n_acc != 4) begin errors++; $display("FAIL b2b_accepts got=%0d exp=4", n_acc); end
        for (int i = 1; i < n_acc; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 21) begin
                errors++;
                $display("FAIL b2b_interval[%0d] got=%0d exp=21", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        wait_got(16, ok);
        checks++;
        if (!ok || got_q.size() != 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), $signed(exp_q[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i = '0;
        test_reset();
        test_impulse();
        test_dc();
        test_random();
        test_backpressure();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
